pwm_channel_gen: RTL and testbench

//  Single-channel PWM generator; consumes one pwm_freqN/pwm_dutyN pair from the SPI register slave.

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm_channel_gen.sv | 148 ++++++++++++++
 tb/tb_pwm_channel_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants, FSM encoding and input-clamp helpers for
//                the PWM channel generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Steps per PWM period; also the full-scale duty value.
    localparam int NSTEP_DEF = 100;

    // Shadow register reset values, matching the SPI register defaults.
    localparam logic [15:0] FREQ_RST = 16'd100;
    localparam logic [6:0]  DUTY_RST = 7'd50;

    // Channel FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_t;

    // A zero step length would never advance; treat it as one tick.
    function automatic logic [15:0] clamp_freq(input logic [15:0] freq);
        return (freq == 16'd0) ? 16'd1 : freq;
    endfunction

    // Duty above full scale saturates at full scale.
    function automatic logic [6:0] clamp_duty(input logic [6:0] duty,
                                              input logic [6:0] nstep);
        return (duty > nstep) ? nstep : duty;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_prescaler
//  Description : Divides the system clock into ticks of CLK_DIV clocks.
//                A synchronous clear re-phases the divider at channel start.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_pre_cnt;

    assign o_tick = (r_pre_cnt == c_last);

    // Free-running divider, wraps to zero on each tick while enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
        end else if (i_clear) begin
            r_pre_cnt <= '0;
        end else if (i_enable) begin
            r_pre_cnt <= o_tick ? '0 : r_pre_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_channel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel_gen
//  Description : Single-channel PWM generator. Frequency and duty inputs are
//                captured into shadow registers only at period boundaries,
//                so the output never glitches on register writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel_gen
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int NSTEP   = NSTEP_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pwm_freq,
    input  logic [6:0]  pwm_duty,
    output logic        pwm_out,
    output logic        period_start,
    output logic [15:0] active_freq,
    output logic [6:0]  active_duty,
    output logic        busy
);

    localparam logic [6:0] c_nstep    = 7'(NSTEP);
    localparam logic [6:0] c_nstep_m1 = 7'(NSTEP - 1);

    pwm_state_t  r_state;
    pwm_state_t  w_state_nxt;

    logic [15:0] r_freq_sh;
    logic [6:0]  r_duty_sh;
    logic [15:0] r_sub_cnt;
    logic [6:0]  r_step_cnt;
    logic        r_pwm_out;
    logic        r_period_start;

    logic        w_tick;
    logic        w_busy;
    logic        w_last_sub;
    logic        w_last_step;
    logic        w_pend;
    logic        w_start;
    logic        w_load;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_last_sub  = (r_sub_cnt == r_freq_sh - 16'd1);
    assign w_last_step = (r_step_cnt == c_nstep_m1);
    assign w_pend      = w_busy & w_tick & w_last_sub & w_last_step;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .i_enable (w_busy),
        .i_clear  (w_start),
        .o_tick   (w_tick)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a load happens at start and at every period end that continues running.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = w_pend ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Re-enabling resumes the period in flight rather than restarting it.
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pend) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_load = w_start | (w_pend & (w_state_nxt == ST_RUN));
    end

    // Shadow registers and step counters; shadows hold their values while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_freq_sh      <= FREQ_RST;
            r_duty_sh      <= DUTY_RST;
            r_sub_cnt      <= 16'd0;
            r_step_cnt     <= 7'd0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_load;
            if (w_load) begin
                r_freq_sh  <= clamp_freq(pwm_freq);
                r_duty_sh  <= clamp_duty(pwm_duty, c_nstep);
                r_sub_cnt  <= 16'd0;
                r_step_cnt <= 7'd0;
            end else if (w_pend) begin
                r_sub_cnt  <= 16'd0;
                r_step_cnt <= 7'd0;
            end else if (w_busy && w_tick) begin
                if (w_last_sub) begin
                    r_sub_cnt  <= 16'd0;
                    r_step_cnt <= r_step_cnt + 7'd1;
                end else begin
                    r_sub_cnt  <= r_sub_cnt + 16'd1;
                end
            end
        end
    end

    // Registered duty compare; lags the counters by one clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_out <= w_busy & (r_step_cnt < r_duty_sh);
        end
    end

    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;
    assign active_freq  = r_freq_sh;
    assign active_duty  = r_duty_sh;
    assign busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_channel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_channel_gen
//  Description : Directed self-checking bench for pwm_channel_gen, with a
//                CLK_DIV=1 instance and a CLK_DIV=4 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_channel_gen;

    logic        clock;
    logic        reset;

    logic        enable;
    logic [15:0] pwm_freq;
    logic [6:0]  pwm_duty;
    logic        pwm_out;
    logic        period_start;
    logic [15:0] active_freq;
    logic [6:0]  active_duty;
    logic        busy;

    logic        enable4;
    logic [15:0] pwm_freq4;
    logic [6:0]  pwm_duty4;
    logic        pwm_out4;
    logic        period_start4;
    logic [15:0] active_freq4;
    logic [6:0]  active_duty4;
    logic        busy4;

    int n_total;
    int n_bad;

    pwm_channel_gen #(.CLK_DIV(1), .NSTEP(100)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pwm_freq     (pwm_freq),
        .pwm_duty     (pwm_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .active_freq  (active_freq),
        .active_duty  (active_duty),
        .busy         (busy)
    );

    pwm_channel_gen #(.CLK_DIV(4), .NSTEP(100)) u_dut4 (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable4),
        .pwm_freq     (pwm_freq4),
        .pwm_duty     (pwm_duty4),
        .pwm_out      (pwm_out4),
        .period_start (period_start4),
        .active_freq  (active_freq4),
        .active_duty  (active_duty4),
        .busy         (busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Hold reset for two clocks with both channels disabled.
    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b0;
        enable  = 1'b0;
        enable4 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Raise enable and check the start-edge cycle.
    task automatic start(input logic [15:0] f, input logic [6:0] d,
                         input logic [15:0] exp_f, input logic [6:0] exp_d);
        @(negedge clock);
        pwm_freq = f;
        pwm_duty = d;
        enable   = 1'b1;
        @(posedge clock);
        #1;
        check_val("start_period_start", period_start, 1);
        check_val("start_busy", busy, 1);
        check_val("start_pwm_out", pwm_out, 0);
        check_val("start_active_freq", active_freq, exp_f);
        check_val("start_active_duty", active_duty, exp_d);
    endtask

    // Cycle k counts edges after the load edge: pwm_out follows the step
    // count of the previous cycle, and period_start marks each period edge.
    task automatic run_check(input int sel, input int per, input int hi,
                             input int off, input int n);
        for (int k = off + 1; k <= off + n; k++) begin
            @(posedge clock);
            #1;
            if (sel == 0) begin
                check_val($sformatf("pwm_out@%0d", k), pwm_out, 32'(((k - 1) % per) < hi));
                check_val($sformatf("period_start@%0d", k), period_start, 32'((k % per) == 0));
                check_val($sformatf("busy@%0d", k), busy, 1);
            end else begin
                check_val($sformatf("div4_pwm_out@%0d", k), pwm_out4, 32'(((k - 1) % per) < hi));
                check_val($sformatf("div4_period_start@%0d", k), period_start4, 32'((k % per) == 0));
                check_val($sformatf("div4_busy@%0d", k), busy4, 1);
            end
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b0;
        enable    = 1'b0;
        pwm_freq  = 16'd0;
        pwm_duty  = 7'd0;
        enable4   = 1'b0;
        pwm_freq4 = 16'd0;
        pwm_duty4 = 7'd0;

        // Reset state.
        #12;
        check_val("rst_pwm_out", pwm_out, 0);
        check_val("rst_period_start", period_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_active_freq", active_freq, 100);
        check_val("rst_active_duty", active_duty, 50);
        check_val("rst_div4_active_freq", active_freq4, 100);
        check_val("rst_div4_busy", busy4, 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: 50% duty, 200-clock period.
        start(16'd2, 7'd50, 16'd2, 7'd50);
        run_check(0, 200, 100, 0, 400);

        // 2: duty limits.
        do_reset();
        start(16'd2, 7'd0, 16'd2, 7'd0);
        run_check(0, 200, 0, 0, 200);
        do_reset();
        start(16'd2, 7'd100, 16'd2, 7'd100);
        run_check(0, 200, 200, 0, 600);
        do_reset();
        start(16'd2, 7'd120, 16'd2, 7'd100);
        run_check(0, 200, 200, 0, 200);

        // 3: mid-period input change applies at the next period.
        do_reset();
        start(16'd2, 7'd50, 16'd2, 7'd50);
        run_check(0, 200, 100, 0, 50);
        pwm_freq = 16'd3;
        pwm_duty = 7'd25;
        run_check(0, 200, 100, 50, 149);
        check_val("chg_hold_freq", active_freq, 2);
        check_val("chg_hold_duty", active_duty, 50);
        run_check(0, 200, 100, 199, 1);
        check_val("chg_new_freq", active_freq, 3);
        check_val("chg_new_duty", active_duty, 25);
        run_check(0, 300, 75, 0, 300);

        // 4a: enable dropped mid-period; period completes then idles.
        do_reset();
        start(16'd2, 7'd50, 16'd2, 7'd50);
        run_check(0, 200, 100, 0, 30);
        enable = 1'b0;
        run_check(0, 200, 100, 30, 169);
        @(posedge clock);
        #1;
        check_val("drain_end_period_start", period_start, 0);
        check_val("drain_end_busy", busy, 0);
        check_val("drain_end_pwm_out", pwm_out, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_val($sformatf("idle_pwm_out@%0d", i), pwm_out, 0);
            check_val($sformatf("idle_busy@%0d", i), busy, 0);
        end
        check_val("idle_hold_freq", active_freq, 2);

        // 4b: enable re-raised during drain; no restart.
        do_reset();
        start(16'd2, 7'd50, 16'd2, 7'd50);
        run_check(0, 200, 100, 0, 30);
        enable = 1'b0;
        run_check(0, 200, 100, 30, 90);
        enable = 1'b1;
        run_check(0, 200, 100, 120, 80);
        run_check(0, 200, 100, 0, 200);

        // 5a: zero step length treated as one.
        do_reset();
        start(16'd0, 7'd50, 16'd1, 7'd50);
        run_check(0, 100, 50, 0, 200);

        // 5b: prescaler of 4, freq=1 gives a 400-clock period.
        do_reset();
        @(negedge clock);
        pwm_freq4 = 16'd1;
        pwm_duty4 = 7'd50;
        enable4   = 1'b1;
        @(posedge clock);
        #1;
        check_val("div4_start_period_start", period_start4, 1);
        check_val("div4_start_active_freq", active_freq4, 1);
        run_check(1, 400, 200, 0, 800);

        // 6: asynchronous reset while the output is high.
        do_reset();
        start(16'd2, 7'd50, 16'd2, 7'd50);
        run_check(0, 200, 100, 0, 40);
        reset = 1'b0;
        #1;
        check_val("async_pwm_out", pwm_out, 0);
        check_val("async_busy", busy, 0);
        check_val("async_period_start", period_start, 0);
        check_val("async_active_freq", active_freq, 100);
        check_val("async_active_duty", active_duty, 50);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("restart_period_start", period_start, 1);
        check_val("restart_busy", busy, 1);
        check_val("restart_active_freq", active_freq, 2);
        run_check(0, 200, 100, 0, 200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
